// File: rtl/wb_stage_if.sv
// Bus bundle between the MEM/hazard side of the pipeline and the WB stage.
// The master side presents the MEM instruction, pipeline control and the ID
// read addresses; the slave side (wb_stage) returns the RF write port, the
// bypass hits and the retired-instruction count.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             mem_valid;
  logic [31:0]      mem_pc4;
  logic [31:0]      mem_alu_c;
  logic [31:0]      mem_ext;
  logic [31:0]      mem_rdo;
  logic [1:0]       mem_rf_wsel;
  logic             mem_rf_we;
  logic [4:0]       mem_wR;
  logic [2:0]       mem_ld_op;
  logic             stall;
  logic             flush;
  logic [4:0]       rR1;
  logic [4:0]       rR2;

  logic             wb_we;
  logic [4:0]       wb_wR;
  logic [31:0]      wb_wD;
  logic             wb_valid;
  logic             fwd1_hit;
  logic             fwd2_hit;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output mem_valid, mem_pc4, mem_alu_c, mem_ext, mem_rdo, mem_rf_wsel,
           mem_rf_we, mem_wR, mem_ld_op, stall, flush, rR1, rR2,
    input  wb_we, wb_wR, wb_wD, wb_valid, fwd1_hit, fwd2_hit, retire_cnt
  );

  modport slave (
    input  mem_valid, mem_pc4, mem_alu_c, mem_ext, mem_rdo, mem_rf_wsel,
           mem_rf_we, mem_wR, mem_ld_op, stall, flush, rR1, rR2,
    output wb_we, wb_wR, wb_wD, wb_valid, fwd1_hit, fwd2_hit, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back pipeline stage: one register holding the MEM instruction,
// load-data extraction, RF write port, WB->ID bypass hits and a counter of
// retired instructions. A held (stalled) entry writes the RF only once.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);

  localparam logic [1:0] RF_WSEL_ALU = 2'd0;
  localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
  localparam logic [1:0] RF_WSEL_EXT = 2'd2;
  localparam logic [1:0] RF_WSEL_RDO = 2'd3;

  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  logic             valid_q;
  logic             written_q;
  logic [31:0]      pc4_q;
  logic [31:0]      alu_c_q;
  logic [31:0]      ext_q;
  logic [31:0]      rdo_q;
  logic [1:0]       wsel_q;
  logic             rf_we_q;
  logic [4:0]       wr_q;
  logic [2:0]       ld_op_q;
  logic [CNT_W-1:0] cnt_q;

  logic             we_int;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic [31:0]      wd_int;

  // WB pipeline register: flush beats stall beats capture. Flush keeps the
  // fields so wb_wD stays a defined function of registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      written_q <= 1'b0;
      pc4_q     <= '0;
      alu_c_q   <= '0;
      ext_q     <= '0;
      rdo_q     <= '0;
      wsel_q    <= '0;
      rf_we_q   <= 1'b0;
      wr_q      <= '0;
      ld_op_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.stall) begin
      // the first held cycle issues the write; later held cycles must not
      if (we_int) written_q <= 1'b1;
    end else begin
      valid_q   <= bus.mem_valid;
      written_q <= 1'b0;
      pc4_q     <= bus.mem_pc4;
      alu_c_q   <= bus.mem_alu_c;
      ext_q     <= bus.mem_ext;
      rdo_q     <= bus.mem_rdo;
      wsel_q    <= bus.mem_rf_wsel;
      rf_we_q   <= bus.mem_rf_we;
      wr_q      <= bus.mem_wR;
      ld_op_q   <= bus.mem_ld_op;
    end
  end

  // Retire counter: a live entry counts when it leaves WB normally; a flushed
  // or reset entry never counts, and a stalled one counts once on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && !bus.stall && !bus.flush) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // RF write enable: never to x0, never twice for one held entry.
  always_comb begin
    we_int = valid_q & rf_we_q & (wr_q != 5'd0) & ~written_q;
  end

  // Load extraction from the raw DRAM word using the address low bits.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = alu_c_q[1] ? rdo_q[31:16] : rdo_q[15:0];
    ld_data = rdo_q;
    case (alu_c_q[1:0])
      2'd0:    ld_byte = rdo_q[7:0];
      2'd1:    ld_byte = rdo_q[15:8];
      2'd2:    ld_byte = rdo_q[23:16];
      default: ld_byte = rdo_q[31:24];
    endcase
    case (ld_op_q)
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_data = {16'h0000, ld_half};
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = rdo_q;
    endcase
  end

  // Write-back source select.
  always_comb begin
    wd_int = alu_c_q;
    case (wsel_q)
      RF_WSEL_ALU: wd_int = alu_c_q;
      RF_WSEL_PC4: wd_int = pc4_q;
      RF_WSEL_EXT: wd_int = ext_q;
      RF_WSEL_RDO: wd_int = ld_data;
      default:     wd_int = alu_c_q;
    endcase
  end

  // Output drive, including the bypass compares against ID read addresses.
  always_comb begin
    bus.wb_we      = we_int;
    bus.wb_wR      = wr_q;
    bus.wb_wD      = wd_int;
    bus.wb_valid   = valid_q;
    bus.fwd1_hit   = we_int & (bus.rR1 == wr_q);
    bus.fwd2_hit   = we_int & (bus.rR2 == wr_q);
    bus.retire_cnt = cnt_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases plus random traffic. The driver updates
// an instruction-level reference model per clock and queues the expected
// post-edge outputs; a monitor compares them one time unit after each edge.
module tb_wb_stage;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] alu_c;
    logic [31:0] ext;
    logic [31:0] rdo;
    logic [1:0]  wsel;
    logic        we;
    logic [4:0]  wr;
    logic [2:0]  op;
    logic        stall;
    logic        flush;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        valid;
    logic        f1;
    logic        f2;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stage_if #(.CNT_W(CNT_W)) bus ();

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b0;
  exp_t exp_q[$];

  // Reference model: the instruction sitting in WB, whether its RF write has
  // already been issued, and how many instructions have retired.
  stim_t m_ent;
  bit    m_issued;
  int    m_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_we();
    return m_ent.valid && m_ent.we && (m_ent.wr != 5'd0) && !m_issued;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdo, input logic [31:0] addr,
                                         input logic [2:0] op);
    logic [31:0] b, h;
    b = (rdo >> (8 * addr[1:0])) & 32'hFF;
    h = (rdo >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return rdo;
    endcase
  endfunction

  function automatic logic [31:0] m_wd();
    case (m_ent.wsel)
      2'd0:    return m_ent.alu_c;
      2'd1:    return m_ent.pc4;
      2'd2:    return m_ent.ext;
      default: return m_load(m_ent.rdo, m_ent.alu_c, m_ent.op);
    endcase
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model over
  // the following rising edge and queue what the DUT should then show.
  task automatic step(input stim_t s, input bit r);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.mem_valid    = s.valid;
    bus.mem_pc4      = s.pc4;
    bus.mem_alu_c    = s.alu_c;
    bus.mem_ext      = s.ext;
    bus.mem_rdo      = s.rdo;
    bus.mem_rf_wsel  = s.wsel;
    bus.mem_rf_we    = s.we;
    bus.mem_wR       = s.wr;
    bus.mem_ld_op    = s.op;
    bus.stall        = s.stall;
    bus.flush        = s.flush;
    bus.rR1          = s.rr1;
    bus.rR2          = s.rr2;
    if (r) begin
      m_ent = '0; m_issued = 0; m_retired = 0;
    end else if (s.flush) begin
      m_ent.valid = 1'b0;
    end else if (s.stall) begin
      if (m_we()) m_issued = 1;
    end else begin
      if (m_ent.valid) m_retired++;
      m_ent = s;
      m_issued = 0;
    end
    e.we    = m_we();
    e.wr    = m_ent.wr;
    e.wd    = m_wd();
    e.valid = m_ent.valid;
    e.f1    = e.we && (s.rr1 == m_ent.wr);
    e.f2    = e.we && (s.rr2 == m_ent.wr);
    e.cnt   = CNT_W'(m_retired % (1 << CNT_W));
    exp_q.push_back(e);
    running = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(bus.wb_we), 32'h0);
    check({tag, "_wR"},    32'(bus.wb_wR), 32'h0);
    check({tag, "_wD"},    bus.wb_wD, 32'h0);
    check({tag, "_valid"}, 32'(bus.wb_valid), 32'h0);
    check({tag, "_fwd"},   32'({bus.fwd1_hit, bus.fwd2_hit}), 32'h0);
    check({tag, "_cnt"},   32'(bus.retire_cnt), 32'h0);
  endtask

  // Asynchronous reset between edges; must follow a step directly.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_ent = '0; m_issued = 0; m_retired = 0;
    #1;
    check_zero("async_rst");
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t instr(input logic [1:0] wsel, input logic [31:0] alu_c,
                                  input logic [31:0] rdo, input logic [2:0] op,
                                  input logic [4:0] wr, input logic we);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.wsel = wsel; s.alu_c = alu_c; s.rdo = rdo; s.op = op;
    s.wr = wr; s.we = we; s.pc4 = 32'h0000_1004; s.ext = 32'hFFFF_FFF0;
    return s;
  endfunction

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_we",      32'(bus.wb_we),      32'(e.we));
        check("wb_wR",      32'(bus.wb_wR),      32'(e.wr));
        check("wb_wD",      bus.wb_wD,           e.wd);
        check("wb_valid",   32'(bus.wb_valid),   32'(e.valid));
        check("fwd1_hit",   32'(bus.fwd1_hit),   32'(e.f1));
        check("fwd2_hit",   32'(bus.fwd2_hit),   32'(e.f2));
        check("retire_cnt", 32'(bus.retire_cnt), 32'(e.cnt));
      end else if (running) begin
        miscompares++;
        $display("FAIL sb_underflow: got no expectation expected one at %0t", $time);
      end
    end
  end

  initial begin
    stim_t s;
    logic [31:0] rdo;
    rdo = 32'h80FF_7F01;
    m_ent = '0; m_issued = 0; m_retired = 0;
    {bus.mem_valid, bus.mem_pc4, bus.mem_alu_c, bus.mem_ext, bus.mem_rdo, bus.mem_rf_wsel,
     bus.mem_rf_we, bus.mem_wR, bus.mem_ld_op, bus.stall, bus.flush, bus.rR1, bus.rR2} = '0;
    #22;
    check_zero("reset");

    // ALU write, first capture right after reset release
    step(instr(2'd0, 32'h0000_1234, 32'h0, 3'd0, 5'd5, 1'b1), 1'b0);
    @(posedge clk); #2;
    check("alu_we", 32'(bus.wb_we), 32'h1);
    check("alu_wR", 32'(bus.wb_wR), 32'd5);
    check("alu_wD", bus.wb_wD, 32'h0000_1234);
    check("alu_cnt0", 32'(bus.retire_cnt), 32'd0);
    step(idle(), 1'b0);
    @(posedge clk); #2;
    check("alu_cnt1", 32'(bus.retire_cnt), 32'd1);

    // load extraction
    step(instr(2'd3, 32'h0000_0102, rdo, 3'd3, 5'd4, 1'b1), 1'b0);
    @(posedge clk); #2; check("lb_off2", bus.wb_wD, 32'hFFFF_FFFF);
    step(instr(2'd3, 32'h0000_0103, rdo, 3'd4, 5'd4, 1'b1), 1'b0);
    @(posedge clk); #2; check("lbu_off3", bus.wb_wD, 32'h0000_0080);
    step(instr(2'd3, 32'h0000_0101, rdo, 3'd1, 5'd4, 1'b1), 1'b0);
    @(posedge clk); #2; check("lh_half0", bus.wb_wD, 32'h0000_7F01);
    step(instr(2'd3, 32'h0000_0103, rdo, 3'd2, 5'd4, 1'b1), 1'b0);
    @(posedge clk); #2; check("lhu_half1", bus.wb_wD, 32'h0000_80FF);

    // x0 never written, bypass compare
    step(instr(2'd0, 32'h5, 32'h0, 3'd0, 5'd0, 1'b1), 1'b0);
    @(posedge clk); #2;
    check("x0_we", 32'(bus.wb_we), 32'h0);
    check("x0_fwd", 32'({bus.fwd1_hit, bus.fwd2_hit}), 32'h0);
    s = instr(2'd0, 32'h7, 32'h0, 3'd0, 5'd7, 1'b1);
    s.rr1 = 5'd7; s.rr2 = 5'd3;
    step(s, 1'b0);
    @(posedge clk); #2;
    check("byp_fwd1", 32'(bus.fwd1_hit), 32'h1);
    check("byp_fwd2", 32'(bus.fwd2_hit), 32'h0);

    // three-cycle stall of a live entry
    step(instr(2'd1, 32'h0, 32'h0, 3'd0, 5'd9, 1'b1), 1'b0);
    s = idle(); s.stall = 1'b1;
    repeat (3) step(s, 1'b0);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    // stall+flush on a live entry
    step(instr(2'd2, 32'h0, 32'h0, 3'd0, 5'd11, 1'b1), 1'b0);
    s = idle(); s.stall = 1'b1; s.flush = 1'b1;
    step(s, 1'b0);
    step(idle(), 1'b0);

    // reset in the middle of a stall
    step(instr(2'd0, 32'hABCD, 32'h0, 3'd0, 5'd9, 1'b1), 1'b0);
    s = idle(); s.stall = 1'b1;
    step(s, 1'b0);
    async_reset();
    step(s, 1'b1);
    step(idle(), 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.pc4   = $urandom;
      s.alu_c = $urandom;
      s.ext   = $urandom;
      s.rdo   = $urandom;
      s.wsel  = 2'($urandom_range(0, 3));
      s.we    = ($urandom_range(0, 3) != 0);
      s.wr    = 5'($urandom_range(0, 7));
      s.op    = 3'($urandom_range(0, 7));
      s.stall = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rr1   = 5'($urandom_range(0, 7));
      s.rr2   = 5'($urandom_range(0, 7));
      step(s, ($urandom_range(0, 99) == 0));
    end
    step(idle(), 1'b0);

    @(posedge clk); #3;
    running = 1'b0;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
